// File: rtl/serial_sub.sv
// ---------------------------------------------------------------------------
// serial_sub
//
// Bit-serial unsigned subtractor: computes a - b one bit per clock, LSB
// first, using a difference/borrow cell iterated over W cycles. Operands
// are captured on an accepted start, the result appears in diff/bout with
// a one-cycle done pulse, and it is held until the next operation ends.
//
// Parameters
//   W      operand/result width in bits (W >= 1)
//
// Ports
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   start  in   begin a subtraction (sampled only in IDLE)
//   a      in   [W-1:0] minuend, captured on the accepted start edge
//   b      in   [W-1:0] subtrahend, captured on the accepted start edge
//   busy   out  high while bits are being processed (RUN)
//   done   out  one-cycle pulse in the cycle diff/bout were updated
//   diff   out  [W-1:0] result register
//   bout   out  borrow out of bit W-1 (1 means a < b, unsigned)
//
// Build option
//   SERIAL_SUB_SAT_EN  when defined, a result that borrows out is clamped
//                      to zero in diff; bout still reports the borrow.
// ---------------------------------------------------------------------------
module serial_sub #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] diff,
    output logic         bout
);

    localparam int CNT_W = $clog2(W + 1);

    // Index of the last bit processed in RUN.
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(W - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [W-1:0]     a_sh_q, a_sh_d;
    logic [W-1:0]     b_sh_q, b_sh_d;
    logic [W-1:0]     res_q, res_d;
    logic             br_q, br_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W-1:0]     diff_q, diff_d;
    logic             bout_q, bout_d;

    // Per-bit cell signals.
    logic             bit_x;
    logic             bit_y;
    logic             bit_d;
    logic             br_next;
    logic [W-1:0]     res_shift;

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        res_d   = res_q;
        br_d    = br_q;
        cnt_d   = cnt_q;
        diff_d  = diff_q;
        bout_d  = bout_q;

        bit_x   = a_sh_q[0];
        bit_y   = b_sh_q[0];
        bit_d   = bit_x ^ bit_y ^ br_q;
        br_next = (~bit_x & bit_y) | (~(bit_x ^ bit_y) & br_q);

        // New difference bit enters at the MSB so that after W shifts the
        // first (LSB) difference bit has arrived at position 0.
        res_shift        = res_q >> 1;
        res_shift[W-1]   = bit_d;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    res_d   = '0;
                    br_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end

            S_RUN: begin
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                res_d  = res_shift;
                br_d   = br_next;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_BIT) begin
                    // The completed result is taken from res_shift, not
                    // res_q, so the final bit lands in the same edge.
`ifdef SERIAL_SUB_SAT_EN
                    diff_d = br_next ? '0 : res_shift;
`else
                    diff_d = res_shift;
`endif
                    bout_d  = br_next;
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            res_q   <= res_d;
            br_q    <= br_d;
            cnt_q   <= cnt_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
        end
    end

    // busy/done decode straight from the state register so they follow an
    // asynchronous reset immediately.
    assign busy = (state_q == S_RUN);
    assign done = (state_q == S_DONE);
    assign diff = diff_q;
    assign bout = bout_q;

endmodule

// File: tb/tb_serial_sub.sv
// ---------------------------------------------------------------------------
// tb_serial_sub
//
// Self-checking bench for serial_sub: a W=8 instance exercised with directed
// and random operations, plus a W=1 instance. Expected results come from
// plain modulo arithmetic on the operands.
// ---------------------------------------------------------------------------
module tb_serial_sub;

    logic       clk;
    logic       rst_n;

    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       busy;
    logic       done;
    logic [7:0] diff;
    logic       bout;

    logic       start1;
    logic [0:0] a1;
    logic [0:0] b1;
    logic       busy1;
    logic       done1;
    logic [0:0] diff1;
    logic       bout1;

    int unsigned n_checks;
    int unsigned n_fail;

    logic [7:0] prev_diff;
    logic       prev_bout;

    serial_sub #(.W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
    );

    serial_sub #(.W(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start1),
        .a     (a1),
        .b     (b1),
        .busy  (busy1),
        .done  (done1),
        .diff  (diff1),
        .bout  (bout1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference: unsigned subtraction modulo 2^width, borrow when a < b.
    function automatic logic [7:0] ref_diff(input int unsigned av, input int unsigned bv,
                                            input int unsigned width);
        int unsigned m;
        int unsigned r;
        m = 1 << width;
        r = (av + m - bv) % m;
`ifdef SERIAL_SUB_SAT_EN
        if (av < bv) r = 0;
`endif
        return 8'(r);
    endfunction

    // Present operands with start for one edge and check acceptance.
    task automatic issue(input logic [7:0] av, input logic [7:0] bv);
        @(negedge clk);
        a     = av;
        b     = bv;
        start = 1'b1;
        @(posedge clk);
        #1;
        check("busy_on_accept", busy, 1);
        check("done_on_accept", done, 0);
    endtask

    // Follow an accepted operation to completion. noise: pulse start and
    // scramble a/b during RUN. hold: keep start high with the next operands
    // (na/nb) so the follow-on start is accepted at the first IDLE edge.
    task automatic finish_op(input logic [7:0] av, input logic [7:0] bv,
                             input bit noise, input bit hold,
                             input logic [7:0] na, input logic [7:0] nb);
        logic [7:0] exp_d;
        logic       exp_b;
        exp_d = ref_diff(av, bv, 8);
        exp_b = (av < bv);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (hold) begin
                start = 1'b1;
                a     = na;
                b     = nb;
            end else if (noise) begin
                start = (k == 3) || (k == 5);
                a     = 8'($urandom);
                b     = 8'($urandom);
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            if (k < 8) begin
                check("busy_in_run", busy, 1);
                check("done_in_run", done, 0);
                check("diff_held", diff, prev_diff);
                check("bout_held", bout, prev_bout);
            end else begin
                check("done_pulse", done, 1);
                check("busy_at_done", busy, 0);
                check("diff_result", diff, exp_d);
                check("bout_result", bout, exp_b);
            end
        end
        prev_diff = exp_d;
        prev_bout = exp_b;
        if (!hold) begin
            @(negedge clk);
            start = 1'b0;
        end
        @(posedge clk);
        #1;
        check("done_cleared", done, 0);
        check("busy_after_done", busy, 0);
        check("diff_kept", diff, prev_diff);
        if (hold) begin
            @(posedge clk);
            #1;
            check("restart_accept", busy, 1);
        end
    endtask

    initial begin
        int unsigned done_seen;
        logic [7:0] ra;
        logic [7:0] rb;

        n_checks  = 0;
        n_fail    = 0;
        prev_diff = '0;
        prev_bout = 1'b0;
        start     = 1'b0;
        a         = '0;
        b         = '0;
        start1    = 1'b0;
        a1        = '0;
        b1        = '0;
        rst_n     = 1'b0;

        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_diff", diff, 0);
        check("rst_bout", bout, 0);
        check("rst_busy_w1", busy1, 0);

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic subtraction with no borrow.
        issue(8'h5A, 8'h23);
        finish_op(8'h5A, 8'h23, 0, 0, 8'h00, 8'h00);

        // Borrow out (wrap or clamp depending on build).
        issue(8'h10, 8'h20);
        finish_op(8'h10, 8'h20, 0, 0, 8'h00, 8'h00);

        // Back-to-back with start held high through DONE.
        issue(8'hFF, 8'hFF);
        finish_op(8'hFF, 8'hFF, 0, 1, 8'h00, 8'h01);
        finish_op(8'h00, 8'h01, 0, 0, 8'h00, 8'h00);

        // start pulses and operand changes during RUN are ignored.
        issue(8'h80, 8'h01);
        finish_op(8'h80, 8'h01, 1, 0, 8'h00, 8'h00);

        // Reset in the middle of an operation.
        issue(8'h33, 8'h11);
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk);
            #1;
            check("busy_pre_abort", busy, 1);
        end
        @(negedge clk);
        start = 1'b0;
        rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_diff", diff, 0);
        check("abort_bout", bout, 0);
        @(negedge clk);
        rst_n = 1'b1;
        prev_diff = '0;
        prev_bout = 1'b0;
        done_seen = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            if (done || busy) done_seen++;
        end
        check("no_done_after_abort", done_seen, 0);
        issue(8'h33, 8'h11);
        finish_op(8'h33, 8'h11, 0, 0, 8'h00, 8'h00);

        // Random operations, some with RUN-time noise.
        for (int n = 0; n < 24; n++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            if (n % 6 == 0) rb = ra;
            if (n % 6 == 1) ra = 8'h00;
            issue(ra, rb);
            finish_op(ra, rb, ($urandom_range(0, 1) == 1), 0, 8'h00, 8'h00);
        end

        // W=1 instance: every operand pair.
        for (int av = 0; av < 2; av++) begin
            for (int bv = 0; bv < 2; bv++) begin
                @(negedge clk);
                a1     = 1'(av);
                b1     = 1'(bv);
                start1 = 1'b1;
                @(posedge clk);
                #1;
                check("w1_busy", busy1, 1);
                check("w1_done_early", done1, 0);
                @(negedge clk);
                start1 = 1'b0;
                a1     = ~a1;
                b1     = ~b1;
                @(posedge clk);
                #1;
                check("w1_done", done1, 1);
                check("w1_busy_off", busy1, 0);
                check("w1_diff", diff1, 32'(ref_diff(av, bv, 1)));
                check("w1_bout", bout1, (av < bv) ? 1 : 0);
                @(posedge clk);
                #1;
                check("w1_done_clear", done1, 0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Hard stop so the bench can never hang.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish (checks=%0d)", n_checks);
        $fatal(1, "timeout");
    end

endmodule
